// File: rtl/culsans_tohost_ctrl.sv
// culsans_tohost_ctrl
//   Host-communication responder. Software writes TOHOST; once a written
//   value has bit0 set, the block latches it onto exit_o ({code, done}).
//   A watchdog forces a failing exit if software never terminates.
//   Also provides a FROMHOST mailbox, a STATUS register and a CLEAR strobe.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   req_i / gnt_o    request, granted combinationally (no backpressure)
//   addr_i           byte address (8-byte aligned)
//   we_i, be_i       write enable, byte enables
//   wdata_i          write data
//   rvalid_o         one-cycle response pulse, one cycle after the grant
//   rdata_o, err_o   read data / error, valid with rvalid_o
//   exit_o           {code[30:0], done}, registered
//
// Register map (offsets from BaseAddr, 4 KiB window)
//   0x00 TOHOST RW, 0x08 FROMHOST RW, 0x10 STATUS RO, 0x18 CLEAR WO
module culsans_tohost_ctrl #(
  parameter int unsigned AddrWidth     = 64,
  parameter logic [63:0] BaseAddr      = 64'h0000_0000_0300_0000,
  parameter logic [31:0] TimeoutCycles = 32'd0,
  parameter logic [30:0] TimeoutCode   = 31'h7FFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [7:0]           be_i,
  input  logic [63:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic                 err_o,
  output logic [31:0]          exit_o
);

  typedef enum logic [1:0] {RUN, DONE, TIMEOUT} state_e;

  localparam logic [AddrWidth-1:0] Base    = BaseAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] WinSize = AddrWidth'(4096);

  state_e      state_q;
  logic [63:0] tohost_q, tohost_d;
  logic [63:0] fromhost_q, fromhost_d;
  logic [31:0] wdog_q, wdog_inc;
  logic [31:0] exit_q;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Address decode: an address below the base wraps to a huge offset,
  // so a single unsigned compare covers both window edges.
  logic [AddrWidth-1:0] off;
  logic in_win, sel_to, sel_from, sel_st, sel_clr, legal;
  logic to_wr, expire;
  logic [63:0] to_merged;

  assign off      = addr_i - Base;
  assign in_win   = (off < WinSize);
  assign sel_to   = in_win && (off[11:0] == 12'h000);
  assign sel_from = in_win && (off[11:0] == 12'h008);
  assign sel_st   = in_win && (off[11:0] == 12'h010);
  assign sel_clr  = in_win && (off[11:0] == 12'h018);
  assign legal    = sel_to || sel_from || (sel_st && !we_i) || (sel_clr && we_i);

  function automatic logic [63:0] merge(input logic [63:0] old_v,
                                        input logic [63:0] new_v,
                                        input logic [7:0]  be);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign gnt_o     = req_i;
  assign to_merged = merge(tohost_q, wdata_i, be_i);
  assign to_wr     = req_i && we_i && sel_to;
  assign wdog_inc  = (wdog_q == 32'hFFFF_FFFF) ? wdog_q : wdog_q + 32'd1;
  // Expiry is the cycle in which the count would reach the limit.
  assign expire    = (TimeoutCycles != 32'd0) && (wdog_q != 32'hFFFF_FFFF) &&
                     (wdog_q + 32'd1 == TimeoutCycles);

  always_comb begin
    tohost_d   = tohost_q;
    fromhost_d = fromhost_q;
    rvalid_d   = req_i;
    err_d      = req_i && !legal;
    rdata_d    = 64'd0;
    if (req_i && legal) begin
      if (we_i) begin
        if (sel_to)   tohost_d   = to_merged;
        if (sel_from) fromhost_d = merge(fromhost_q, wdata_i, be_i);
        if (sel_clr)  fromhost_d = 64'd0;
      end else begin
        // Reads see the pre-write register values.
        if (sel_to)   rdata_d = tohost_q;
        if (sel_from) rdata_d = fromhost_q;
        if (sel_st)   rdata_d = {wdog_q, 30'd0, state_q == TIMEOUT, state_q != RUN};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      tohost_q   <= 64'd0;
      fromhost_q <= 64'd0;
      wdog_q     <= 32'd0;
      exit_q     <= 32'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      case (state_q)
        RUN: begin
          // A terminating write beats a same-cycle watchdog expiry.
          if (to_wr && to_merged[0]) begin
            state_q <= DONE;
            exit_q  <= to_merged[31:0];
            wdog_q  <= 32'd0;
          end else if (to_wr) begin
            wdog_q  <= 32'd0;
          end else if (expire) begin
            state_q <= TIMEOUT;
            exit_q  <= {TimeoutCode, 1'b1};
            wdog_q  <= wdog_inc;
          end else begin
            wdog_q  <= wdog_inc;
          end
        end
        default: ; // DONE / TIMEOUT absorb until reset; watchdog holds
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign exit_o   = exit_q;

endmodule

// File: tb/tb_culsans_tohost_ctrl.sv
// Self-checking bench for culsans_tohost_ctrl: a vector table on an
// instance without watchdog, and hand sequences for watchdog, collision
// and asynchronous reset on a second instance with TimeoutCycles=100.
module tb_culsans_tohost_ctrl;
  localparam logic [63:0] BASE = 64'h0000_0000_0300_0000;
  localparam logic [63:0] TOH = BASE, FRH = BASE + 64'h8, STS = BASE + 64'h10,
                          CLR = BASE + 64'h18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, req0, req1, we;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic        gnt0, gnt1, rv0, rv1, er0, er1;
  logic [63:0] rd0, rd1;
  logic [31:0] ex0, ex1;

  culsans_tohost_ctrl #(.TimeoutCycles(32'd0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .req_i(req0), .gnt_o(gnt0), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv0), .rdata_o(rd0),
    .err_o(er0), .exit_o(ex0));

  culsans_tohost_ctrl #(.TimeoutCycles(32'd100)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .gnt_o(gnt1), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv1), .rdata_o(rd1),
    .err_o(er1), .exit_o(ex1));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one access, returns at the next negedge
  // with the response sampled.
  task automatic acc(input bit which, input logic [63:0] a, input logic w,
                     input logic [7:0] b, input logic [63:0] d,
                     output logic g, output logic v, output logic [63:0] r,
                     output logic e);
    addr = a; we = w; be = b; wdata = d;
    if (which) req1 = 1'b1; else req0 = 1'b1;
    #1 g = which ? gnt1 : gnt0;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    v = which ? rv1 : rv0;
    r = which ? rd1 : rd0;
    e = which ? er1 : er0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_exit;
  } vec_t;

  vec_t vt[14];
  logic g, v, e;
  logic [63:0] r;

  initial begin
    vt[0]  = '{TOH, 1'b1, 8'hFF, 64'h1,                   64'h0, 1'b0, 32'h1};
    vt[1]  = '{STS, 1'b0, 8'hFF, 64'h0,                   64'h1, 1'b0, 32'h1};
    vt[2]  = '{TOH, 1'b0, 8'hFF, 64'h0,                   64'h1, 1'b0, 32'h1};
    vt[3]  = '{FRH, 1'b1, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b0, 32'h1};
    vt[4]  = '{FRH, 1'b1, 8'h01, 64'h55,                  64'h0, 1'b0, 32'h1};
    vt[5]  = '{FRH, 1'b0, 8'hFF, 64'h0, 64'hAAAA_AAAA_AAAA_AA55, 1'b0, 32'h1};
    vt[6]  = '{BASE + 64'h20, 1'b0, 8'hFF, 64'h0,         64'h0, 1'b1, 32'h1};
    vt[7]  = '{STS, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 32'h1};
    vt[8]  = '{BASE - 64'h8, 1'b1, 8'hFF, 64'h0,          64'h0, 1'b1, 32'h1};
    vt[9]  = '{BASE - 64'h8, 1'b0, 8'hFF, 64'h0,          64'h0, 1'b1, 32'h1};
    vt[10] = '{FRH, 1'b0, 8'hFF, 64'h0, 64'hAAAA_AAAA_AAAA_AA55, 1'b0, 32'h1};
    vt[11] = '{CLR, 1'b1, 8'hFF, 64'h0,                   64'h0, 1'b0, 32'h1};
    vt[12] = '{FRH, 1'b0, 8'hFF, 64'h0,                   64'h0, 1'b0, 32'h1};
    vt[13] = '{TOH, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 32'h1};

    rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
    addr = '0; we = 1'b0; be = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_exit", {32'd0, ex0}, 64'd0);
    chk("reset_rvalid", {63'd0, rv0}, 64'd0);
    chk("reset_rdata", rd0, 64'd0);
    chk("reset_err", {63'd0, er0}, 64'd0);
    chk("reset_gnt", {63'd0, gnt0}, 64'd0);
    rst0 = 1'b0;
    @(negedge clk);

    // Table vectors, issued back to back.
    for (int i = 0; i < 14; i++) begin
      acc(1'b0, vt[i].addr, vt[i].we, vt[i].be, vt[i].wdata, g, v, r, e);
      chk($sformatf("v%0d_gnt", i), {63'd0, g}, 64'd1);
      chk($sformatf("v%0d_rvalid", i), {63'd0, v}, 64'd1);
      chk($sformatf("v%0d_rdata", i), r, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), {63'd0, e}, {63'd0, vt[i].exp_err});
      chk($sformatf("v%0d_exit", i), {32'd0, ex0}, {32'd0, vt[i].exp_exit});
    end
    acc(1'b0, TOH, 1'b0, 8'hFF, 64'h0, g, v, r, e);
    chk("be0_noop_tohost", r, 64'h1);
    @(negedge clk);
    chk("idle_rvalid", {63'd0, rv0}, 64'd0);

    // Code 3 exit, then absorbing DONE.
    rst0 = 1'b1; @(negedge clk); rst0 = 1'b0; @(negedge clk);
    chk("rst_clears_exit", {32'd0, ex0}, 64'd0);
    acc(1'b0, TOH, 1'b1, 8'hFF, 64'h7, g, v, r, e);
    chk("exit_code3", {32'd0, ex0}, 64'h7);
    acc(1'b0, TOH, 1'b1, 8'hFF, 64'h1, g, v, r, e);
    chk("exit_absorbing", {32'd0, ex0}, 64'h7);
    acc(1'b0, TOH, 1'b0, 8'hFF, 64'h0, g, v, r, e);
    chk("tohost_readback", r, 64'h1);

    // Asynchronous reset while exit_o = 3.
    rst0 = 1'b1; @(negedge clk); rst0 = 1'b0; @(negedge clk);
    acc(1'b0, TOH, 1'b1, 8'hFF, 64'h3, g, v, r, e);
    chk("exit_3", {32'd0, ex0}, 64'h3);
    #2 rst0 = 1'b1;
    #1 chk("async_rst_exit", {32'd0, ex0}, 64'd0);
    chk("async_rst_rvalid", {63'd0, rv0}, 64'd0);
    @(negedge clk); rst0 = 1'b0;

    // Watchdog expiry at cycle 100.
    rst1 = 1'b0;
    repeat (99) @(negedge clk);
    chk("wd_before", {32'd0, ex1}, 64'd0);
    @(negedge clk);
    chk("wd_expire", {32'd0, ex1}, 64'hFFFF_FFFF);
    acc(1'b1, STS, 1'b0, 8'hFF, 64'h0, g, v, r, e);
    chk("wd_status_timeout", {63'd0, r[1]}, 64'd1);
    chk("wd_status_count", {32'd0, r[63:32]}, 64'd100);
    acc(1'b1, TOH, 1'b1, 8'hFF, 64'h9, g, v, r, e);
    chk("wd_absorbing", {32'd0, ex1}, 64'hFFFF_FFFF);

    // bit0=0 write at cycle 60 delays expiry to cycle 160.
    rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
    repeat (59) @(negedge clk);
    acc(1'b1, TOH, 1'b1, 8'hFF, 64'h2, g, v, r, e);
    chk("syscall_no_exit", {32'd0, ex1}, 64'd0);
    repeat (99) @(negedge clk);
    chk("wd_delayed_before", {32'd0, ex1}, 64'd0);
    @(negedge clk);
    chk("wd_delayed_expire", {32'd0, ex1}, 64'hFFFF_FFFF);

    // Terminating write in the expiry cycle wins.
    rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
    repeat (99) @(negedge clk);
    chk("coll_before", {32'd0, ex1}, 64'd0);
    acc(1'b1, TOH, 1'b1, 8'hFF, 64'h5, g, v, r, e);
    chk("coll_done", {32'd0, ex1}, 64'h5);
    repeat (20) @(negedge clk);
    chk("coll_stays_done", {32'd0, ex1}, 64'h5);
    acc(1'b1, STS, 1'b0, 8'hFF, 64'h0, g, v, r, e);
    chk("coll_status", r, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/culsans_tohost_ctrl.md
Name: culsans_tohost_ctrl

Overview:
- Memory-mapped host-communication responder that produces the 32-bit exit word consumed by the integration testbench.
- Software running on the Culsans cores writes a tohost word; once its LSB is set, the block latches and drives exit_o. Bit 0 means done, bits 31:1 carry the return code.
- Also provides a fromhost mailbox, a status register, and a watchdog that forces a failing exit if software never terminates.
- Sits on a simple req/gnt/rvalid peripheral port behind the SoC crossbar.

Parameters:
- AddrWidth, 64, width of addr_i (byte address).
- BaseAddr, 64'h0000_0000_0300_0000, base of the 4 KiB register window.
- TimeoutCycles, 32'd0, watchdog limit in clk_i cycles; 0 disables the watchdog.
- TimeoutCode, 31'h7FFF_FFFF, return code reported on watchdog expiry.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  access request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  AddrWidth  byte address, 8-byte aligned
- we_i  in  1  1 = write, 0 = read
- be_i  in  8  byte enables
- wdata_i  in  64  write data
- rvalid_o  out  1  response valid
- rdata_o  out  64  read data
- err_o  out  1  response error, valid with rvalid_o
- exit_o  out  32  {code[30:0], done}

Behaviour:
- Reset values: all registers 0, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, exit_o=0. Reset asserted mid-operation clears everything, including a latched exit and any pending response.
- Register map, offsets from BaseAddr:
  - 0x00 TOHOST: 64 bit, RW.
  - 0x08 FROMHOST: 64 bit, RW.
  - 0x10 STATUS: RO; bit0 = done, bit1 = timeout, bits63:32 = watchdog count.
  - 0x18 CLEAR: WO; any write clears FROMHOST.
  - Any other offset inside the window, or any address outside it, returns err_o=1 with rdata_o=0 and has no side effects.
- Handshake:
  - gnt_o = req_i combinationally; there is no backpressure.
  - Response comes exactly 1 cycle after the grant: rvalid_o pulses for one cycle.
  - Back-to-back requests produce back-to-back responses.
- Writes:
  - Byte-merged per be_i into the target register.
  - be_i=0 is a legal no-op and still gets a response.
  - Writes to STATUS respond with err_o=1.
- Reads return the register value from before any write accepted in the same cycle. Reading TOHOST returns the last written value.
- Exit state machine:
  - States are RUN, DONE, TIMEOUT.
  - RUN -> DONE on a TOHOST write whose merged value has bit0=1. In the cycle after the write, exit_o = merged[31:0] (code = merged[31:1]).
  - RUN -> TIMEOUT when the watchdog count reaches TimeoutCycles (TimeoutCycles != 0). exit_o becomes {TimeoutCode, 1'b1} and STATUS.timeout is set.
  - DONE and TIMEOUT are absorbing until reset. Later TOHOST writes update the register but never change exit_o.
  - If a bit0=1 TOHOST write lands in the same cycle the watchdog expires, the TOHOST write wins: the block enters DONE.
  - A TOHOST write with bit0=0 (e.g. a syscall or console request) updates TOHOST only and does not change state.
- Watchdog:
  - 32-bit counter that increments every cycle in RUN.
  - Resets to 0 on any accepted TOHOST write.
  - Holds its value in DONE and TIMEOUT.
  - Saturates at 32'hFFFF_FFFF and never wraps.
- exit_o is registered, with no combinational path from the inputs.

Test Plan:
- Reset, then write TOHOST=64'h1 with be=8'hFF -> exit_o=32'h1 in the following cycle; rvalid_o pulses 1 cycle after gnt; STATUS read = 0x...01.
- Write TOHOST=64'h7 -> exit_o=32'h7 (code 3); a later write of 64'h1 leaves exit_o=32'h7 while a TOHOST read returns 64'h1.
- TimeoutCycles=100 with no accesses -> exit_o=32'hFFFF_FFFF at cycle 100 and STATUS bit1=1; a bit0=0 TOHOST write at cycle 60 delays expiry to cycle 160.
- Byte merge: write FROMHOST=64'hAAAA_AAAA_AAAA_AAAA with be=FF, then 64'h55 with be=8'h01 -> read returns 64'hAAAA_AAAA_AAAA_AA55; a write to CLEAR -> read returns 0.
- Read of offset 0x20, a write to STATUS, and an access at BaseAddr-8 -> each gives err_o=1 and rdata_o=0, with no state change.
- Same-cycle collision: a bit0=1 write at the watchdog expiry cycle gives DONE with the written code. Asserting rst_i while exit_o=32'h3 clears exit_o to 0 asynchronously.
